lsnn_spike_decoder: RTL
=======================

# lsnn_spike_decoder

Output-side decoder for the LSNN Tiny Tapeout design. It counts spikes from each output neuron over a programmable window of network timesteps and picks the most active neuron as the classification result. It then drives the 7-segment pins (`uo_out[6:0]`) with the winning class index. The block sits directly downstream of the LSNN core and consumes its per-timestep output spike vector.

## Interface
- `N_OUT`, 4: number of output neurons / classes (2..10).
- `CNT_W`, 8: per-neuron spike counter width.
- `WIN_W`, 8: window length width, counted in timesteps.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low. One clock; all flops reset asynchronously by `rst_n` low.
- `ena` in 1: design enable. When low, all state is frozen.
- `tick` in 1: one-cycle strobe marking the end of an LSNN timestep; `spikes` is valid on this cycle.
- `spikes` in N_OUT: output spike vector from the LSNN core.
- `start` in 1: one-cycle pulse that begins a window.
- `win_len` in WIN_W: window length in ticks. Sampled on `start`; a value of 0 is treated as 1.
- `busy` out 1: high in COUNT and COMPARE.
- `result_valid` out 1: one-cycle pulse when a new result is latched.
- `winner` out 4: latched winning index. `4'hF` means no spikes were seen.
- `segments` out 7: 7-segment pattern for `winner`, active-high, bits {g,f,e,d,c,b,a}.

## Operation
- States: IDLE → COUNT → COMPARE → DONE → IDLE (or COUNT; see Configuration).
- IDLE, on `start`:
  - clear all counters;
  - load `win_rem` with `max(win_len,1)`;
  - go to COUNT.
  - `start` in any other state is ignored.
- COUNT, on each `tick`:
  - for every i with `spikes[i]`=1, `cnt[i]` += 1, saturating at 2^CNT_W−1;
  - `win_rem` −= 1;
  - when `win_rem` reaches 0 on this tick, go to COMPARE next cycle.
  - Spikes arriving without `tick` are ignored.
- COMPARE runs a sequential argmax, one neuron per cycle, index 0 to N_OUT−1.
  - The running best is replaced only when `cnt[i]` is strictly greater.
  - A tie therefore resolves to the lowest index.
  - If the final best count is 0, the winner is `4'hF`.
- DONE, for one cycle:
  - latch `winner` and `segments`;
  - pulse `result_valid`.
- Display encoding:
  - digits 0–9 use the standard 7-segment patterns;
  - `4'hF` shows a dash (segment g only, `7'b1000000`).
- `ena`=0 freezes everything:
  - no state transitions and no counting;
  - `tick` and `start` are ignored;
  - outputs hold their values.

## Timing
- Reset values: state IDLE, all counters 0, `busy`=0, `result_valid`=0, `winner`=4'hF, `segments`=7'b1000000.
- Latency from `start` to entering COUNT: 1 cycle.
- Latency from the final `tick` to `result_valid`: N_OUT+1 cycles (N_OUT COMPARE cycles plus DONE).
- `winner` and `segments` change only in the DONE cycle and hold until the next DONE.
- Counter saturation: a counter at 255 (CNT_W=8) stays at 255 on further spikes, with no wrap.
- A `tick` in the same cycle as `start` (IDLE) is not counted. Counting begins with the first tick after COUNT is entered.
- If `rst_n` is asserted mid-window or mid-compare, the block returns immediately to its reset values. A partial result is never emitted.

## Configuration
- `LSNN_DEC_CONTINUOUS_EN` defined:
  - DONE goes straight to COUNT;
  - counters are cleared and `win_rem` is reloaded from the current `win_len`;
  - back-to-back windows run without `start`.
  - Ticks arriving during COMPARE or DONE are dropped.
- Undefined: DONE goes to IDLE and waits for `start`.

## Structure
- Package `lsnn_dec_pkg` holds:
  - the state enum `dec_state_t` (IDLE, COUNT, COMPARE, DONE);
  - `NO_WINNER` = 4'hF;
  - the segment constants `SEG_0`..`SEG_9` and `SEG_DASH`.
- Sub-module `lsnn_seg7`: a combinational 4-bit index to 7-segment encoder. Its output is registered in the parent at DONE.

## Test plan
- Case 1: N_OUT=4, win_len=5; neuron 2 spikes on all 5 ticks, others on 1 → `result_valid` 5 cycles after the last tick; `winner`=2, `segments`=7'b1011011.
- Case 2: tie with `cnt[1]`=`cnt[3]`=3 → `winner`=1.
- Case 3: no spikes over win_len=3 → `winner`=4'hF, `segments`=7'b1000000, `result_valid` pulses.
- Case 4: saturation with win_len=255 and win_len then raised; neuron 0 spikes every tick across two windows, CNT_W=4 build → `cnt[0]` holds at 15 and `winner`=0.
- Case 5: `rst_n` low for 1 cycle mid-COUNT → all outputs return to reset values; a subsequent `start` runs a clean window.
- Case 6: hold `ena`=0 across 3 ticks mid-window → those ticks are uncounted and `win_rem` is unchanged. With `LSNN_DEC_CONTINUOUS_EN`, a second `result_valid` follows with no `start`.

Source files
------------

// File: rtl/lsnn_dec_pkg.sv
// Shared types and constants for the LSNN output spike decoder.
package lsnn_dec_pkg;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        COMPARE,
        DONE
    } dec_state_t;

    localparam logic [IDX_W-1:0] NO_WINNER = 4'hF;

    // Segment bit order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [SEG_W-1:0] SEG_0    = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1    = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2    = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3    = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4    = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5    = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6    = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7    = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8    = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9    = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'b1000000;

endpackage

// File: rtl/lsnn_seg7.sv
// Combinational class-index to 7-segment encoder; non-digit indices show a dash.
module lsnn_seg7
    import lsnn_dec_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output logic [SEG_W-1:0] seg_c
);

    // Digit lookup
    always_comb begin
        seg_c = SEG_DASH;
        case (idx_i)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/lsnn_spike_decoder.sv
// LSNN output decoder: counts output spikes over a window of timesteps,
// picks the most active neuron (ties to lowest index) and shows it on 7 segments.
// Optional: define LSNN_DEC_CONTINUOUS_EN to restart a new window after each result.
module lsnn_spike_decoder
    import lsnn_dec_pkg::*;
#(
    parameter int unsigned N_OUT = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             tick,
    input  logic [N_OUT-1:0] spikes,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    output logic             busy,
    output logic             result_valid,
    output logic [3:0]       winner,
    output logic [6:0]       segments
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    dec_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q [N_OUT];
    logic [CNT_W-1:0] cnt_d [N_OUT];
    logic [WIN_W-1:0] win_rem_q, win_rem_d, win_load_c;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d, cand_idx_c;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d, cand_cnt_c, sel_cnt_c;
    logic             busy_d, result_valid_d;
    logic [IDX_W-1:0] winner_d;
    logic [SEG_W-1:0] segments_d, seg_c;

    // Window length with zero promoted to one
    assign win_load_c = (win_len == '0) ? WIN_W'(1) : win_len;

    // Counter of the neuron currently under comparison
    always_comb begin
        sel_cnt_c = '0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            if (idx_q == IDX_W'(i)) sel_cnt_c = cnt_q[i];
        end
    end

    // Running argmax step: replace only on strictly greater count
    assign cand_idx_c = (sel_cnt_c > best_cnt_q) ? idx_q     : best_idx_q;
    assign cand_cnt_c = (sel_cnt_c > best_cnt_q) ? sel_cnt_c : best_cnt_q;

    lsnn_seg7 u_seg7 (
        .idx_i (cand_idx_c),
        .seg_c (seg_c)
    );

    // Next-state and datapath logic
    always_comb begin
        state_d        = state_q;
        win_rem_d      = win_rem_q;
        idx_d          = idx_q;
        best_idx_d     = best_idx_q;
        best_cnt_d     = best_cnt_q;
        winner_d       = winner;
        segments_d     = segments;
        result_valid_d = 1'b0;
        for (int unsigned i = 0; i < N_OUT; i++) cnt_d[i] = cnt_q[i];

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int unsigned i = 0; i < N_OUT; i++) cnt_d[i] = '0;
                    win_rem_d = win_load_c;
                    state_d   = COUNT;
                end
            end
            COUNT: begin
                if (tick) begin
                    for (int unsigned i = 0; i < N_OUT; i++) begin
                        if (spikes[i] && (cnt_q[i] != CNT_MAX)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                    win_rem_d = win_rem_q - WIN_W'(1);
                    if (win_rem_q == WIN_W'(1)) begin
                        idx_d      = '0;
                        best_idx_d = NO_WINNER;
                        best_cnt_d = '0;
                        state_d    = COMPARE;
                    end
                end
            end
            COMPARE: begin
                best_idx_d = cand_idx_c;
                best_cnt_d = cand_cnt_c;
                idx_d      = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    winner_d       = cand_idx_c;
                    segments_d     = seg_c;
                    result_valid_d = 1'b1;
                    state_d        = DONE;
                end
            end
            DONE: begin
`ifdef LSNN_DEC_CONTINUOUS_EN
                for (int unsigned i = 0; i < N_OUT; i++) cnt_d[i] = '0;
                win_rem_d = win_load_c;
                state_d   = COUNT;
`else
                state_d   = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == COUNT) || (state_d == COMPARE);
    end

    // State and output registers; ena low freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            win_rem_q    <= '0;
            idx_q        <= '0;
            best_idx_q   <= NO_WINNER;
            best_cnt_q   <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            winner       <= NO_WINNER;
            segments     <= SEG_DASH;
            for (int unsigned i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
        end else if (ena) begin
            state_q      <= state_d;
            win_rem_q    <= win_rem_d;
            idx_q        <= idx_d;
            best_idx_q   <= best_idx_d;
            best_cnt_q   <= best_cnt_d;
            busy         <= busy_d;
            result_valid <= result_valid_d;
            winner       <= winner_d;
            segments     <= segments_d;
            for (int unsigned i = 0; i < N_OUT; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule
